// File: rtl/multiport_register_file.sv
// multiport_register_file: two write ports and three combinational read ports.
// Also provides optional same-cycle write bypass and a per-entry pending-write scoreboard.
//
// Ports:
//   clk               clock; all state updates on the rising edge
//   rst               asynchronous active-low reset
//   WE0/WA0/WD0       write port 0 (ALU writeback)
//   WE1/WA1/WD1       write port 1 (load writeback); wins when both
//                     ports target the same address
//   RA0..RA2          read addresses
//   RD0..RD2          combinational read data
//   BusySet/BusyAddr  mark a destination register as pending
//   Busy0..Busy2      pending status of RA0..RA2
module multiport_register_file #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              WE0,
   input  logic [ADDR_W-1:0] WA0,
   input  logic [DATA_W-1:0] WD0,
   input  logic              WE1,
   input  logic [ADDR_W-1:0] WA1,
   input  logic [DATA_W-1:0] WD1,
   input  logic [ADDR_W-1:0] RA0,
   input  logic [ADDR_W-1:0] RA1,
   input  logic [ADDR_W-1:0] RA2,
   output logic [DATA_W-1:0] RD0,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   input  logic              BusySet,
   input  logic [ADDR_W-1:0] BusyAddr,
   output logic              Busy0,
   output logic              Busy1,
   output logic              Busy2
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wr0;
   logic              wr1;
   logic              bset;
   logic [ADDR_W-1:0] ra [3];
   logic [DATA_W-1:0] rd [3];
   logic              rb [3];

   function automatic logic prot(input logic [ADDR_W-1:0] a);
      return ZERO_REG && (a == '0);
   endfunction

   // Qualified enables: writes and busy-sets to a protected
   // entry 0 never reach the state.
   assign wr0  = WE0 && !prot(WA0);
   assign wr1  = WE1 && !prot(WA1);
   assign bset = BusySet && !prot(BusyAddr);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         busy <= '0;
      end else begin
         // Port 1 is assigned last so it wins an address clash.
         if (wr0) mem[WA0] <= WD0;
         if (wr1) mem[WA1] <= WD1;
         for (int i = 0; i < DEPTH; i++) begin
            if ((wr0 && WA0 == ADDR_W'(i)) ||
                (wr1 && WA1 == ADDR_W'(i))) begin
               busy[i] <= 1'b0;
            end
            // A newly issued producer overrides a retiring one.
            if (bset && BusyAddr == ADDR_W'(i)) begin
               busy[i] <= 1'b1;
            end
         end
      end
   end

   assign ra[0] = RA0;
   assign ra[1] = RA1;
   assign ra[2] = RA2;

   always_comb begin
      for (int p = 0; p < 3; p++) begin
         rd[p] = mem[ra[p]];
         rb[p] = busy[ra[p]];
         if (BYPASS) begin
            if (wr1 && WA1 == ra[p]) begin
               rd[p] = WD1;
               rb[p] = 1'b0;
            end else if (wr0 && WA0 == ra[p]) begin
               rd[p] = WD0;
               rb[p] = 1'b0;
            end
         end
         // Reset hides any bypassed write data as well.
         if (!rst || prot(ra[p])) begin
            rd[p] = '0;
            rb[p] = 1'b0;
         end
      end
   end

   assign RD0   = rd[0];
   assign RD1   = rd[1];
   assign RD2   = rd[2];
   assign Busy0 = rb[0];
   assign Busy1 = rb[1];
   assign Busy2 = rb[2];

endmodule
